// File: rtl/oled_msg_pkg.sv
// Shared types and helpers for the OLED message sequencer.
// Width functions, FSM state encoding and a few ASCII constants.
package oled_msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int f_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int f_sw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int f_lw(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam logic [7:0] CHR_H = 8'h68;
  localparam logic [7:0] CHR_E = 8'h65;
  localparam logic [7:0] CHR_L = 8'h6C;
  localparam logic [7:0] CHR_O = 8'h6F;

endpackage

// File: rtl/oled_msg_ram.sv
// Message store: one write port, one registered read port.
// A same-cycle write and read of one address returns the old byte.
module oled_msg_ram
  import oled_msg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  localparam int RAW   = f_aw(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [RAW-1:0]    i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [RAW-1:0]    i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/oled_msg_sequencer.sv
// Streams one of NUM_MSGS stored messages into the OLED byte sink,
// with backpressure, optional looping, inter-byte gap and abort.
module oled_msg_sequencer
  import oled_msg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MSG_DEPTH  = 16,
  parameter int NUM_MSGS   = 4,
  parameter int GAP_CYCLES = 0,
  localparam int SW        = f_sw(NUM_MSGS),
  localparam int AW        = f_aw(MSG_DEPTH),
  localparam int LW        = f_lw(MSG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_we,
  input  logic [SW-1:0]     i_ld_slot,
  input  logic [AW-1:0]     i_ld_idx,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_len_we,
  input  logic [LW-1:0]     i_len_data,
  input  logic              i_start,
  input  logic [SW-1:0]     i_msg_sel,
  input  logic              i_repeat_en,
  input  logic              i_abort,
  input  logic              i_buffer_full,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_write_enable,
  output logic              o_busy,
  output logic              o_done
);

  localparam int RD  = NUM_MSGS * MSG_DEPTH;
  localparam int RAW = f_aw(RD);
  localparam logic [7:0] GAP_LAST =
    8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LEN_MAX = LW'(MSG_DEPTH);

  state_t            r_state, w_state;
  logic [SW-1:0]     r_slot, w_slot;
  logic              r_rep, w_rep;
  logic [LW-1:0]     r_len, w_len;
  logic [AW-1:0]     r_idx, w_idx;
  logic [7:0]        r_gap, w_gap;
  logic              r_we, w_we;
  logic [DATA_W-1:0] r_dout, w_dout;
  logic              r_done, w_done;
  logic              r_busy, w_busy;

  logic [LW-1:0]     r_lens [NUM_MSGS];
  logic [LW-1:0]     w_len_clamp;
  logic [DATA_W-1:0] w_rdata;
  logic [RAW-1:0]    w_waddr;
  logic [RAW-1:0]    w_raddr;
  logic              w_re;
  logic              w_last;
  logic [AW-1:0]     w_idx_after;
  state_t            w_st_after;

  function automatic logic [RAW-1:0] f_addr(
    input logic [SW-1:0] s,
    input logic [AW-1:0] i
  );
    return RAW'(s) * RAW'(MSG_DEPTH) + RAW'(i);
  endfunction

  assign w_waddr = f_addr(i_ld_slot, i_ld_idx);
  assign w_raddr = f_addr(r_slot, r_idx);
  assign w_re    = (r_state == ST_FETCH);

  oled_msg_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RD)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (i_ld_we),
    .i_waddr (w_waddr),
    .i_wdata (i_ld_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_len_clamp =
    (i_len_data > LEN_MAX) ? LEN_MAX : i_len_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_MSGS; s++) r_lens[s] <= '0;
    end else if (i_len_we) begin
      r_lens[i_ld_slot] <= w_len_clamp;
    end
  end

  // what follows a written byte: next index, wrap, or finish
  assign w_last      = (LW'(r_idx) == r_len - LW'(1));
  assign w_idx_after = w_last ? '0 : r_idx + AW'(1);
  assign w_st_after  = (w_last && !r_rep) ? ST_DONE : ST_FETCH;

  always_comb begin
    w_state = r_state;
    w_slot  = r_slot;
    w_rep   = r_rep;
    w_len   = r_len;
    w_idx   = r_idx;
    w_gap   = r_gap;
    w_we    = 1'b0;
    w_dout  = r_dout;
    w_done  = 1'b0;
    if (i_abort) begin
      w_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_slot  = i_msg_sel;
            w_rep   = i_repeat_en;
            w_len   = r_lens[i_msg_sel];
            w_idx   = '0;
            w_state = (r_lens[i_msg_sel] == '0) ?
                      ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: w_state = ST_SEND;
        ST_SEND: begin
          if (!i_buffer_full) begin
            w_we   = 1'b1;
            w_dout = w_rdata;
            if (GAP_CYCLES > 0) begin
              w_state = ST_GAP;
              w_gap   = '0;
            end else begin
              w_state = w_st_after;
              w_idx   = w_idx_after;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_state = w_st_after;
            w_idx   = w_idx_after;
          end else begin
            w_gap = r_gap + 8'd1;
          end
        end
        ST_DONE: begin
          w_done  = !r_rep;
          w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_rep   <= 1'b0;
      r_len   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_we    <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_slot  <= w_slot;
      r_rep   <= w_rep;
      r_len   <= w_len;
      r_idx   <= w_idx;
      r_gap   <= w_gap;
      r_we    <= w_we;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  assign o_data_out     = r_dout;
  assign o_write_enable = r_we;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_oled_msg_sequencer.sv
// Bench for oled_msg_sequencer: two instances (no gap, gap of 3)
// driven together and compared against a write/done schedule model.
module tb_oled_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_we;
  logic [1:0] ld_slot;
  logic [3:0] ld_idx;
  logic [7:0] ld_data;
  logic       len_we;
  logic [4:0] len_data;
  logic       start;
  logic [1:0] msg_sel;
  logic       repeat_en;
  logic       abort;
  logic       full;

  logic [7:0] do0, do1;
  logic       we0, we1, busy0, busy1, done0, done1;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  int w0c[$], w0d[$], d0c[$];
  int w1c[$], w1d[$], d1c[$];

  int mem_m [4][16];
  int len_m [4];
  bit full_rel [512];

  int sc_t, sc_len, sc_n, sc_abort, sc_slot;
  bit sc_rep;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oled_msg_sequencer #(.GAP_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_reset(reset),
    .i_ld_we(ld_we), .i_ld_slot(ld_slot),
    .i_ld_idx(ld_idx), .i_ld_data(ld_data),
    .i_len_we(len_we), .i_len_data(len_data),
    .i_start(start), .i_msg_sel(msg_sel),
    .i_repeat_en(repeat_en), .i_abort(abort),
    .i_buffer_full(full),
    .o_data_out(do0), .o_write_enable(we0),
    .o_busy(busy0), .o_done(done0)
  );

  oled_msg_sequencer #(.GAP_CYCLES(3)) u_dut1 (
    .i_clk(clk), .i_reset(reset),
    .i_ld_we(ld_we), .i_ld_slot(ld_slot),
    .i_ld_idx(ld_idx), .i_ld_data(ld_data),
    .i_len_we(len_we), .i_len_data(len_data),
    .i_start(start), .i_msg_sel(msg_sel),
    .i_repeat_en(repeat_en), .i_abort(abort),
    .i_buffer_full(full),
    .o_data_out(do1), .o_write_enable(we1),
    .o_busy(busy1), .o_done(done1)
  );

  always @(negedge clk) begin
    if (we0) begin
      w0c.push_back(cyc);
      w0d.push_back(int'(do0));
    end
    if (we1) begin
      w1c.push_back(cyc);
      w1d.push_back(int'(do1));
    end
    if (done0) d0c.push_back(cyc);
    if (done1) d1c.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_msg(input int s, input int b[16], input int l);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      ld_we   = 1'b1;
      ld_slot = 2'(s);
      ld_idx  = 4'(i);
      ld_data = 8'(b[i]);
      mem_m[s][i] = b[i] & 255;
    end
    @(posedge clk); #1;
    ld_we    = 1'b0;
    len_we   = 1'b1;
    ld_slot  = 2'(s);
    len_data = 5'(l);
    len_m[s] = (l > 16) ? 16 : l;
    @(posedge clk); #1;
    len_we = 1'b0;
  endtask

  function automatic bit full_at(input int c);
    int r;
    r = c - sc_t;
    return (r >= 0 && r < sc_n) ? full_rel[r] : 1'b0;
  endfunction

  // Expected schedule: bytes every 2+gap cycles from start+3, each
  // slipping past cycles where the sink was full one cycle earlier.
  task automatic check_run(input string nm, input int gap,
                           input int wc[$], input int wd[$],
                           input int dc[$]);
    int ec[$], ed[$], edc[$];
    int c, i, d;
    bit go;
    if (sc_len == 0) begin
      d = sc_t + 2;
      if (!sc_rep && !(sc_abort >= 0 && sc_abort <= d - 1))
        edc.push_back(d);
    end else begin
      c  = sc_t + 3;
      i  = 0;
      go = 1'b1;
      while (go) begin
        while (c < sc_t + sc_n && full_at(c - 1)) c++;
        if (c >= sc_t + sc_n) go = 1'b0;
        else if (sc_abort >= 0 && c > sc_abort) go = 1'b0;
        else begin
          ec.push_back(c);
          ed.push_back(mem_m[sc_slot][i]);
          i++;
          if (i == sc_len) begin
            if (sc_rep) i = 0;
            else begin
              d = c + 1 + gap;
              if (!(sc_abort >= 0 && sc_abort <= d - 1))
                edc.push_back(d);
              go = 1'b0;
            end
          end
          c = c + 2 + gap;
        end
      end
    end
    chk({nm, "_nwr"}, wc.size(), ec.size());
    for (int k = 0; k < ec.size() && k < wc.size(); k++) begin
      chk($sformatf("%s_wcyc%0d", nm, k), wc[k] - sc_t, ec[k] - sc_t);
      chk($sformatf("%s_wdat%0d", nm, k), wd[k], ed[k]);
    end
    chk({nm, "_ndone"}, dc.size(), edc.size());
    if (dc.size() == 1 && edc.size() == 1)
      chk({nm, "_dcyc"}, dc[0] - sc_t, edc[0] - sc_t);
  endtask

  task automatic run(input int slot, input bit rep,
                     input int abort_rel, input int spur_rel,
                     input int n);
    w0c.delete(); w0d.delete(); d0c.delete();
    w1c.delete(); w1d.delete(); d1c.delete();
    sc_slot = slot;
    sc_len  = len_m[slot];
    sc_rep  = rep;
    sc_n    = n;
    for (int r = 0; r < n; r++) begin
      @(posedge clk); #1;
      if (r == 0) sc_t = cyc;
      start     = (r == 0) || (r == spur_rel);
      msg_sel   = 2'((r == spur_rel) ? slot + 1 : slot);
      repeat_en = (r == spur_rel) ? !rep : rep;
      full      = full_rel[r];
      abort     = (r == abort_rel);
      if (abort_rel >= 0 && r == abort_rel + 1) begin
        @(negedge clk);
        chk("abort_busy0", int'(busy0), 0);
        chk("abort_busy1", int'(busy1), 0);
        chk("abort_we0", int'(we0), 0);
        chk("abort_we1", int'(we1), 0);
      end
    end
    sc_abort = (abort_rel >= 0) ? sc_t + abort_rel : -1;
    @(posedge clk); #1;
    start = 1'b0;
    full  = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_run("g0", 0, w0c, w0d, d0c);
    check_run("g3", 3, w1c, w1d, d1c);
    chk("idle_busy0", int'(busy0), 0);
    chk("idle_busy1", int'(busy1), 0);
  endtask

  task automatic clr_full();
    for (int i = 0; i < 512; i++) full_rel[i] = 1'b0;
  endtask

  initial begin
    int b[16];
    int s, l, ab, sp;
    bit rp;
    reset = 1'b1; ld_we = 1'b0; ld_slot = '0; ld_idx = '0;
    ld_data = '0; len_we = 1'b0; len_data = '0; start = 1'b0;
    msg_sel = '0; repeat_en = 1'b0; abort = 1'b0; full = 1'b0;
    for (int k = 0; k < 4; k++) len_m[k] = 0;
    clr_full();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we0", int'(we0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_do0", int'(do0), 0);
    chk("rst_we1", int'(we1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_do1", int'(do1), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    b = '{default: 0};
    b[0] = 'h68; b[1] = 'h65; b[2] = 'h6C; b[3] = 'h6C; b[4] = 'h6F;
    load_msg(0, b, 5);
    run(0, 1'b0, -1, 2, 60);
    for (int r = 6; r < 16; r++) full_rel[r] = 1'b1;
    run(0, 1'b0, -1, -1, 80);
    clr_full();

    b = '{default: 0};
    b[0] = 'h41; b[1] = 'h42;
    load_msg(1, b, 2);
    run(1, 1'b0, -1, -1, 40);

    b = '{default: 0};
    b[0] = 'h78; b[1] = 'h79;
    load_msg(2, b, 2);
    run(2, 1'b1, 12, -1, 40);

    load_msg(3, b, 0);
    run(3, 1'b0, -1, -1, 20);

    for (int i = 0; i < 16; i++) b[i] = int'($urandom_range(0, 255));
    load_msg(3, b, 31);
    run(3, 1'b0, -1, -1, 120);

    run(0, 1'b0, 0, -1, 20);

    for (int it = 0; it < 12; it++) begin
      s = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++)
          b[i] = int'($urandom_range(0, 255));
        l = int'($urandom_range(0, 31));
        load_msg(s, b, l);
      end
      for (int r = 0; r < 300; r++)
        full_rel[r] = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 2) == 0);
      if (rp) ab = int'($urandom_range(5, 150));
      else if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, 60));
      else ab = -1;
      sp = (len_m[s] > 0 && (ab < 0 || ab > 2)) ? 2 : -1;
      run(s, rp, ab, sp, 300);
      clr_full();
    end

    @(posedge clk); #1;
    start = 1'b1; msg_sel = 2'd0; repeat_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; full = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy0", int'(busy0), 1);
    chk("pre_rst_busy1", int'(busy1), 1);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we0", int'(we0), 0);
    chk("mid_rst_busy0", int'(busy0), 0);
    chk("mid_rst_do0", int'(do0), 0);
    chk("mid_rst_we1", int'(we1), 0);
    chk("mid_rst_busy1", int'(busy1), 0);
    chk("mid_rst_do1", int'(do1), 0);
    @(posedge clk); #1;
    reset = 1'b0; full = 1'b0;
    for (int k = 0; k < 4; k++) len_m[k] = 0;
    run(0, 1'b0, -1, -1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
